// File: rtl/cop_issue_driver.sv
// Coprocessor issue driver: buffers CPU requests in a small FIFO and runs
// one COP transaction at a time (issue, wait with timeout, respond).
module cop_issue_driver #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   output logic        g_clk_req,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_insn_enc,
   input  logic [31:0] req_rs1,
   output logic        cop_in_valid,
   input  logic        cop_in_ready,
   output logic [31:0] cop_insn_enc,
   output logic [31:0] cop_rs1,
   input  logic        cop_out_valid,
   output logic        cop_out_ready,
   input  logic [2:0]  cop_result,
   input  logic        cop_rd_wen,
   input  logic [4:0]  cop_rd_addr,
   input  logic [31:0] cop_rd_data,
   output logic        rsp_valid,
   output logic        rsp_timeout,
   output logic [2:0]  rsp_result,
   output logic        rsp_rd_wen,
   output logic [4:0]  rsp_rd_addr,
   output logic [31:0] rsp_rd_data,
   output logic [10:0] tx_i_count,
   output logic [10:0] tx_o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [NW-1:0] FULL_N  = NW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic [31:0]   insn_q, insn_d;
   logic [31:0]   rs1_q, rs1_d;
   logic          in_valid_q, in_valid_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_to_q, rsp_to_d;
   logic [2:0]    rsp_res_q, rsp_res_d;
   logic          rsp_wen_q, rsp_wen_d;
   logic [4:0]    rsp_addr_q, rsp_addr_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic [10:0]   tx_i_q, tx_i_d;
   logic [10:0]   tx_o_q, tx_o_d;

   logic          push;
   logic          pop;
   logic          empty;
   logic [63:0]   head;

   assign push  = req_valid && req_ready_q;
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      insn_d      = insn_q;
      rs1_d       = rs1_q;
      in_valid_d  = in_valid_q;
      wait_d      = wait_q;
      rsp_valid_d = 1'b0;
      rsp_to_d    = rsp_to_q;
      rsp_res_d   = rsp_res_q;
      rsp_wen_d   = rsp_wen_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      tx_i_d      = tx_i_q;
      tx_o_d      = tx_o_q;
      pop         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cop_in_ready) begin
               in_valid_d = 1'b0;
               wait_d     = '0;
               tx_i_d     = tx_i_q + 11'd1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            wait_d = wait_q + 1'b1;
            // a response on the last allowed cycle still wins over timeout
            if (cop_out_valid) begin
               rsp_valid_d = 1'b1;
               rsp_to_d    = 1'b0;
               rsp_res_d   = cop_result;
               rsp_wen_d   = cop_rd_wen;
               rsp_addr_d  = cop_rd_wen ? cop_rd_addr : 5'd0;
               rsp_data_d  = cop_rd_wen ? cop_rd_data : 32'd0;
               tx_o_d      = tx_o_q + 11'd1;
               state_d     = RESP;
            end else if (wait_q == TO_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_to_d    = 1'b1;
               rsp_res_d   = 3'b111;
               rsp_wen_d   = 1'b0;
               rsp_addr_d  = 5'd0;
               rsp_data_d  = 32'd0;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         insn_d     = head[63:32];
         rs1_d      = head[31:0];
         in_valid_d = 1'b1;
         rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_comb begin
      cnt_d       = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      req_ready_d = (cnt_d != FULL_N);
   end

   always_ff @(posedge g_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_insn_enc, req_rs1};
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         insn_q      <= '0;
         rs1_q       <= '0;
         in_valid_q  <= 1'b0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_to_q    <= 1'b0;
         rsp_res_q   <= '0;
         rsp_wen_q   <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
         tx_i_q      <= '0;
         tx_o_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         insn_q      <= insn_d;
         rs1_q       <= rs1_d;
         in_valid_q  <= in_valid_d;
         wait_q      <= wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_to_q    <= rsp_to_d;
         rsp_res_q   <= rsp_res_d;
         rsp_wen_q   <= rsp_wen_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
         tx_i_q      <= tx_i_d;
         tx_o_q      <= tx_o_d;
      end
   end

   assign g_clk_req     = !empty || (state_q != IDLE);
   assign req_ready     = req_ready_q;
   assign cop_in_valid  = in_valid_q;
   assign cop_insn_enc  = insn_q;
   assign cop_rs1       = rs1_q;
   assign cop_out_ready = (state_q == WAIT);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_timeout   = rsp_to_q;
   assign rsp_result    = rsp_res_q;
   assign rsp_rd_wen    = rsp_wen_q;
   assign rsp_rd_addr   = rsp_addr_q;
   assign rsp_rd_data   = rsp_data_q;
   assign tx_i_count    = tx_i_q;
   assign tx_o_count    = tx_o_q;

endmodule

// File: tb/tb_cop_issue_driver.sv
// Directed bench for cop_issue_driver (DEPTH=4, TIMEOUT=8).
// COP side is driven by hand; expected values are fixed constants.
module tb_cop_issue_driver;

   logic        g_clk;
   logic        g_resetn;
   logic        g_clk_req;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_insn_enc;
   logic [31:0] req_rs1;
   logic        cop_in_valid;
   logic        cop_in_ready;
   logic [31:0] cop_insn_enc;
   logic [31:0] cop_rs1;
   logic        cop_out_valid;
   logic        cop_out_ready;
   logic [2:0]  cop_result;
   logic        cop_rd_wen;
   logic [4:0]  cop_rd_addr;
   logic [31:0] cop_rd_data;
   logic        rsp_valid;
   logic        rsp_timeout;
   logic [2:0]  rsp_result;
   logic        rsp_rd_wen;
   logic [4:0]  rsp_rd_addr;
   logic [31:0] rsp_rd_data;
   logic [10:0] tx_i_count;
   logic [10:0] tx_o_count;

   int nchk = 0;
   int nerr = 0;

   cop_issue_driver #(.DEPTH(4), .TIMEOUT(8)) dut (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .g_clk_req     (g_clk_req),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_insn_enc  (req_insn_enc),
      .req_rs1       (req_rs1),
      .cop_in_valid  (cop_in_valid),
      .cop_in_ready  (cop_in_ready),
      .cop_insn_enc  (cop_insn_enc),
      .cop_rs1       (cop_rs1),
      .cop_out_valid (cop_out_valid),
      .cop_out_ready (cop_out_ready),
      .cop_result    (cop_result),
      .cop_rd_wen    (cop_rd_wen),
      .cop_rd_addr   (cop_rd_addr),
      .cop_rd_data   (cop_rd_data),
      .rsp_valid     (rsp_valid),
      .rsp_timeout   (rsp_timeout),
      .rsp_result    (rsp_result),
      .rsp_rd_wen    (rsp_rd_wen),
      .rsp_rd_addr   (rsp_rd_addr),
      .rsp_rd_data   (rsp_rd_data),
      .tx_i_count    (tx_i_count),
      .tx_o_count    (tx_o_count)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic push(input logic [31:0] insn, input logic [31:0] rs1);
      int n;
      n = 0;
      req_valid    = 1'b1;
      req_insn_enc = insn;
      req_rs1      = rs1;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("push_wait", 64'(n), 64'd0);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_wait();
      int n;
      n = 0;
      while (!cop_out_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("wait_entry", 64'(n), 64'd0);
   endtask

   task automatic do_txn(input logic [31:0] exp_insn, input bit chk,
                         input int dly, input logic [2:0] res,
                         input logic wen, input logic [4:0] addr,
                         input logic [31:0] data);
      int n;
      n = 0;
      cop_in_ready = 1'b1;
      while (!cop_in_valid && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("issue_wait", 64'(n), 64'd0);
      if (chk) check("issue_insn", 64'(cop_insn_enc), 64'(exp_insn));
      tick();
      if (chk) check("wait_ordy", 64'(cop_out_ready), 64'd1);
      repeat (dly) tick();
      cop_out_valid = 1'b1;
      cop_result    = res;
      cop_rd_wen    = wen;
      cop_rd_addr   = addr;
      cop_rd_data   = data;
      tick();
      cop_out_valid = 1'b0;
      if (chk) check("rsp_pulse", 64'(rsp_valid), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] ins [5];
   bit seen;
   int n;

   initial begin
      g_resetn      = 1'b0;
      req_valid     = 1'b0;
      req_insn_enc  = '0;
      req_rs1       = '0;
      cop_in_ready  = 1'b0;
      cop_out_valid = 1'b0;
      cop_result    = '0;
      cop_rd_wen    = 1'b0;
      cop_rd_addr   = '0;
      cop_rd_data   = '0;
      ins[0] = 32'h0000_1001;
      ins[1] = 32'h0000_2002;
      ins[2] = 32'h0000_3003;
      ins[3] = 32'h0000_4004;
      ins[4] = 32'h0000_5005;

      // reset state
      repeat (2) tick();
      check("rst_rdy", 64'(req_ready), 64'd0);
      check("rst_clkreq", 64'(g_clk_req), 64'd0);
      check("rst_txi", 64'(tx_i_count), 64'd0);
      check("rst_rspv", 64'(rsp_valid), 64'd0);
      g_resetn = 1'b1;
      tick();
      check("rel_rdy", 64'(req_ready), 64'd1);

      // basic transaction, response in second WAIT cycle
      push(32'h0000_100B, 32'h5);
      do_txn(32'h0000_100B, 1, 1, 3'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      check("t1_rs1", 64'(cop_rs1), 64'h5);
      check("t1_to", 64'(rsp_timeout), 64'd0);
      check("t1_res", 64'(rsp_result), 64'd0);
      check("t1_wen", 64'(rsp_rd_wen), 64'd1);
      check("t1_addr", 64'(rsp_rd_addr), 64'd3);
      check("t1_data", 64'(rsp_rd_data), 64'hDEAD_BEEF);
      check("t1_txi", 64'(tx_i_count), 64'd1);
      check("t1_txo", 64'(tx_o_count), 64'd1);
      tick();
      check("t1_pulse_end", 64'(rsp_valid), 64'd0);
      check("t1_hold", 64'(rsp_rd_data), 64'hDEAD_BEEF);

      // response on the last WAIT cycle, rd_wen low zeroes addr/data
      cop_in_ready = 1'b1;
      push(32'hA2, 32'h0);
      wait_wait();
      repeat (7) tick();
      check("t31_no_early", 64'(rsp_valid), 64'd0);
      cop_out_valid = 1'b1;
      cop_result    = 3'd2;
      cop_rd_wen    = 1'b0;
      cop_rd_addr   = 5'd9;
      cop_rd_data   = 32'h1234;
      tick();
      cop_out_valid = 1'b0;
      check("t31_rspv", 64'(rsp_valid), 64'd1);
      check("t31_to", 64'(rsp_timeout), 64'd0);
      check("t31_res", 64'(rsp_result), 64'd2);
      check("t31_addr", 64'(rsp_rd_addr), 64'd0);
      check("t31_data", 64'(rsp_rd_data), 64'd0);
      check("t31_txo", 64'(tx_o_count), 64'd2);

      // timeout after exactly 8 WAIT cycles
      push(32'hA3, 32'h0);
      wait_wait();
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check("t30_lat", 64'(n), 64'd8);
      check("t30_to", 64'(rsp_timeout), 64'd1);
      check("t30_res", 64'(rsp_result), 64'd7);
      check("t30_wen", 64'(rsp_rd_wen), 64'd0);
      check("t30_txi", 64'(tx_i_count), 64'd3);
      check("t30_txo", 64'(tx_o_count), 64'd2);
      cop_out_valid = 1'b1;
      cop_rd_wen    = 1'b1;
      seen = 0;
      repeat (3) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      cop_out_valid = 1'b0;
      check("t30_late_pulse", 64'(seen), 64'd0);
      check("t30_late_txo", 64'(tx_o_count), 64'd2);
      check("t30_ordy", 64'(cop_out_ready), 64'd0);

      // FIFO fill with COP stalled
      cop_in_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(ins[i], 32'(i));
      check("t29_full", 64'(req_ready), 64'd0);
      check("t29_ival", 64'(cop_in_valid), 64'd1);
      check("t29_head", 64'(cop_insn_enc), 64'(ins[0]));
      req_valid    = 1'b1;
      req_insn_enc = 32'hBAD;
      seen = 0;
      repeat (3) begin
         tick();
         if (req_ready) seen = 1;
         if (cop_insn_enc != ins[0]) seen = 1;
      end
      req_valid = 1'b0;
      check("t29_stall", 64'(seen), 64'd0);
      for (int i = 0; i < 5; i++)
         do_txn(ins[i], 1, 0, 3'd1, 1'b1, 5'd7, 32'hC0DE_0000 + 32'(i));
      check("t29_txi", 64'(tx_i_count), 64'd8);
      check("t29_txo", 64'(tx_o_count), 64'd7);
      repeat (2) tick();
      check("t29_drained", 64'(g_clk_req), 64'd0);

      // asynchronous reset mid-WAIT
      cop_in_ready = 1'b1;
      push(32'hA4, 32'h0);
      wait_wait();
      tick();
      g_resetn = 1'b0;
      #1;
      check("t32_ordy", 64'(cop_out_ready), 64'd0);
      check("t32_txi", 64'(tx_i_count), 64'd0);
      check("t32_txo", 64'(tx_o_count), 64'd0);
      check("t32_data", 64'(rsp_rd_data), 64'd0);
      check("t32_rdy", 64'(req_ready), 64'd0);
      check("t32_clkreq", 64'(g_clk_req), 64'd0);
      seen = 0;
      repeat (3) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      g_resetn = 1'b1;
      repeat (2) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      check("t32_no_pulse", 64'(seen), 64'd0);

      // 2048 transactions wrap both counters
      for (int i = 0; i < 2048; i++) begin
         push(32'(i), 32'h0);
         do_txn(32'(i), 0, 0, 3'd0, 1'b0, 5'd0, 32'd0);
         if (i == 2046) begin
            check("t33_txi_max", 64'(tx_i_count), 64'd2047);
            check("t33_txo_max", 64'(tx_o_count), 64'd2047);
         end
      end
      check("t33_txi_wrap", 64'(tx_i_count), 64'd0);
      check("t33_txo_wrap", 64'(tx_o_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
